// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: two-lane PHY link-training sequencer; define LANE_DEGRADE_EN to allow single-lane fallback at timeout
module phy_link_ctrl #(
  parameter int LOCK_TIMEOUT  = 64,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8,
  parameter int RETRY_W       = 2
) (
  input  logic               clk_f,
  input  logic               reset,
  input  logic               active_lane_0,
  input  logic               active_lane_1,
  input  logic               valid_in,
  output logic               tx_train,
  output logic               link_up,
  output logic               valid_gated,
  output logic [1:0]         lane_mask,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retrain_count,
  output logic               link_error
);
  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_TRAIN   = 3'd1,
    S_STABLE  = 3'd2,
    S_LINK_UP = 3'd3,
    S_RECOVER = 3'd4,
    S_ERROR   = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, stable_q, stable_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0] mask_q, mask_d;
  logic tx_q, tx_d, up_q, up_d, err_q, err_d;
  logic locked, timeout, at_max;
  assign locked  = &({active_lane_1, active_lane_0} | ~mask_q);
  assign timeout = timer_q == CNT_W'(LOCK_TIMEOUT - 1);
  assign at_max  = retry_q == RETRY_W'(MAX_RETRIES);
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    mask_d   = mask_q;
    case (state_q)
      S_RESET: begin
        state_d = S_TRAIN;
        timer_d = '0;
      end
      S_TRAIN: begin
        timer_d = timer_q + 1'b1;
        if (locked) begin
          state_d  = S_STABLE;
          stable_d = '0;
        end else if (timeout) begin
          timer_d = '0;
`ifdef LANE_DEGRADE_EN
          if (active_lane_0 ^ active_lane_1) begin
            mask_d   = {active_lane_1, active_lane_0};
            state_d  = S_STABLE;
            stable_d = '0;
          end else
`endif
          if (at_max) state_d = S_ERROR;
          else retry_d = retry_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked) state_d = S_TRAIN;
        else if (stable_q == CNT_W'(STABLE_CYCLES - 1)) state_d = S_LINK_UP;
        else stable_d = stable_q + 1'b1;
      end
      S_LINK_UP: state_d = locked ? S_LINK_UP : S_RECOVER;
      S_RECOVER: begin
        if (at_max) state_d = S_ERROR;
        else begin
          state_d = S_TRAIN;
          retry_d = retry_q + 1'b1;
          timer_d = '0;
          mask_d  = 2'b11;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
    // outputs are registered, so they are decoded from the next state
    tx_d  = state_d == S_TRAIN || state_d == S_STABLE || state_d == S_RECOVER;
    up_d  = state_d == S_LINK_UP;
    err_d = state_d == S_ERROR;
  end
  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q  <= S_RESET;
      timer_q  <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      mask_q   <= 2'b11;
      tx_q     <= 1'b0;
      up_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      mask_q   <= mask_d;
      tx_q     <= tx_d;
      up_q     <= up_d;
      err_q    <= err_d;
    end
  end
  assign state         = state_q;
  assign tx_train      = tx_q;
  assign link_up       = up_q;
  assign link_error    = err_q;
  assign lane_mask     = mask_q;
  assign retrain_count = retry_q;
  assign valid_gated   = valid_in & up_q;
endmodule
